mc_datapath_hs: RTL and testbench

Parametrised multicycle datapath for the 16-bit TSC-style CPU. It holds PC, IR, MDR, A, B, ALUOut, the output port and a 4-entry register file, and is driven step by step by the existing control FSM. Its single shared memory port uses a req/ack handshake with arbitrary wait states. The datapath stalls automatically while memory is busy and flags a bus error if an access times out.

---
 rtl/mc_dp_pkg.sv | 63 ++++++
 rtl/mc_regfile.sv | 45 ++++
 rtl/mc_datapath_hs.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_mc_datapath_hs.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_dp_pkg.sv
// mc_dp_pkg: shared encodings for the multicycle datapath (mc_datapath_hs)
// and its register file.
//   - control-field encodings: ALU op, PC source, mem-to-reg, reg-dst,
//     ALU source B, branch condition
//   - datapath run state (running / halted / bus error)
//   - register file geometry
package mc_dp_pkg;

    localparam int unsigned RF_DEPTH = 4;
    localparam int unsigned RF_AW    = 2;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOT = 3'd4,
        ALU_NEG = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SRA = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'd0,
        PC_SRC_ALUOUT = 2'd1,
        PC_SRC_JUMP   = 2'd2,
        PC_SRC_A      = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        M2R_ALUOUT = 2'd0,
        M2R_MDR    = 2'd1,
        M2R_PC     = 2'd2,
        M2R_IMM_HI = 2'd3
    } mem_to_reg_e;

    typedef enum logic [1:0] {
        RD_IR_9_8 = 2'd0,
        RD_IR_7_6 = 2'd1,
        RD_LINK   = 2'd2
    } reg_dst_e;

    typedef enum logic [1:0] {
        SRCB_B    = 2'd0,
        SRCB_ONE  = 2'd1,
        SRCB_IMM  = 2'd2,
        SRCB_ZERO = 2'd3
    } alu_src_b_e;

    typedef enum logic [1:0] {
        BR_NZ  = 2'd0,
        BR_Z   = 2'd1,
        BR_GTZ = 2'd2,
        BR_LTZ = 2'd3
    } br_cond_e;

    typedef enum logic [1:0] {
        DP_RUN    = 2'd0,
        DP_HALTED = 2'd1,
        DP_BUSERR = 2'd2
    } dp_state_e;

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 4 x WORD_W register file for mc_datapath_hs.
//   clk, reset_n      : clock, synchronous active-low reset (clears all entries)
//   we, waddr, wdata  : synchronous write port (caller gates we with commit)
//   raddr_a / rdata_a : asynchronous read port A
//   raddr_b / rdata_b : asynchronous read port B
module mc_regfile
    import mc_dp_pkg::*;
#(
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [RF_AW-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [RF_AW-1:0]  raddr_a,
    input  logic [RF_AW-1:0]  raddr_b,
    output logic [WORD_W-1:0] rdata_a,
    output logic [WORD_W-1:0] rdata_b
);

    logic [WORD_W-1:0] regs_q [RF_DEPTH];
    logic [WORD_W-1:0] regs_d [RF_DEPTH];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < RF_DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/mc_datapath_hs.sv
// mc_datapath_hs: multicycle datapath for the 16-bit TSC-style CPU with a
// req/ack memory port. Holds PC, IR, MDR, A, B, ALUOut, the output port and
// a 4-entry register file; stalls while memory is busy and raises a sticky
// bus error when an access waits WAIT_MAX cycles (0 = no timeout).
//   clk, reset_n        : clock, synchronous active-low reset
//   mem_*               : shared memory port (req held until ack)
//   ctrl_*, halt        : per-step controls from the control FSM
//   inst, output_port   : IR and WWD output register
//   stall               : current step is not committing this cycle
//   bus_error, halted   : sticky status, cleared only by reset
//   cycle_cnt, stall_cnt, commit_cnt : performance counters, built only
//                         when MC_DP_PERF_CNT_EN is defined, else tied to 0
module mc_datapath_hs
    import mc_dp_pkg::*;
#(
    parameter int unsigned WORD_W   = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned WAIT_MAX = 64,
    parameter int unsigned LINK_REG = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              ctrl_ir_write,
    input  logic              ctrl_mem_read,
    input  logic              ctrl_mem_write,
    input  logic              ctrl_pc_write,
    input  logic              ctrl_pc_write_cond,
    input  logic              ctrl_reg_write,
    input  logic              ctrl_alu_src_a,
    input  logic              ctrl_write_port,
    input  logic              halt,
    input  logic [1:0]        ctrl_pc_source,
    input  logic [1:0]        ctrl_mem_to_reg,
    input  logic [1:0]        ctrl_reg_dst,
    input  logic [1:0]        ctrl_alu_src_b,
    input  logic [1:0]        ctrl_br_cond,
    input  logic [2:0]        ctrl_alu_op,
    output logic [WORD_W-1:0] inst,
    output logic [WORD_W-1:0] output_port,
    output logic              stall,
    output logic              bus_error,
    output logic              halted,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       commit_cnt
);

    localparam int unsigned WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam bit          TIMEOUT_EN = (WAIT_MAX != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [WORD_W-1:0] mdr_q, mdr_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic [WORD_W-1:0] alu_out_q, alu_out_d;
    logic [WORD_W-1:0] out_port_q, out_port_d;
    dp_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              run;
    logic              access_req;
    logic              mem_is_read;
    logic              commit;
    logic [WORD_W-1:0] src_a, src_b, imm_sext, alu_res, next_pc;
    logic              cond;
    logic              pc_en;
    logic [RF_AW-1:0]  rf_waddr;
    logic [WORD_W-1:0] rf_wdata, rf_rdata_a, rf_rdata_b;

    // ---------------- memory port ----------------
    assign run         = (state_q == DP_RUN);
    assign access_req  = ctrl_ir_write | ctrl_mem_write | ctrl_mem_read;
    assign mem_is_read = ctrl_mem_read & ~ctrl_ir_write & ~ctrl_mem_write;
    assign mem_req     = access_req & reset_n & run;
    assign mem_we      = ~ctrl_ir_write & ctrl_mem_write;
    assign mem_addr    = ctrl_ir_write ? pc_q : alu_out_q;
    assign mem_wdata   = b_q;

    assign stall  = (mem_req & ~mem_ack) | ~run;
    assign commit = ~stall;

    // ---------------- ALU ----------------
    assign imm_sext = WORD_W'($signed(ir_q[7:0]));
    assign src_a    = ctrl_alu_src_a ? a_q : pc_q;

    always_comb begin
        src_b = b_q;
        unique case (alu_src_b_e'(ctrl_alu_src_b))
            SRCB_B:    src_b = b_q;
            SRCB_ONE:  src_b = WORD_W'(1);
            SRCB_IMM:  src_b = imm_sext;
            SRCB_ZERO: src_b = '0;
            default:   src_b = b_q;
        endcase
    end

    always_comb begin
        alu_res = '0;
        unique case (alu_op_e'(ctrl_alu_op))
            ALU_ADD: alu_res = src_a + src_b;
            ALU_SUB: alu_res = src_a - src_b;
            ALU_AND: alu_res = src_a & src_b;
            ALU_OR:  alu_res = src_a | src_b;
            ALU_NOT: alu_res = ~src_a;
            ALU_NEG: alu_res = '0 - src_a;
            ALU_SHL: alu_res = src_a << 1;
            ALU_SRA: alu_res = WORD_W'($signed(src_a) >>> 1);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        unique case (br_cond_e'(ctrl_br_cond))
            BR_NZ:   cond = |alu_res;
            BR_Z:    cond = ~|alu_res;
            BR_GTZ:  cond = ~alu_res[WORD_W-1] & (|alu_res);
            BR_LTZ:  cond = alu_res[WORD_W-1];
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = alu_res;
        unique case (pc_src_e'(ctrl_pc_source))
            PC_SRC_ALU:    next_pc = alu_res;
            PC_SRC_ALUOUT: next_pc = alu_out_q;
            PC_SRC_JUMP:   next_pc = {pc_q[WORD_W-1:12], ir_q[11:0]};
            PC_SRC_A:      next_pc = a_q;
            default:       next_pc = alu_res;
        endcase
    end

    assign pc_en = ctrl_pc_write | (ctrl_pc_write_cond & cond);

    // ---------------- register file ----------------
    always_comb begin
        rf_waddr = ir_q[9:8];
        unique case (reg_dst_e'(ctrl_reg_dst))
            RD_IR_9_8: rf_waddr = ir_q[9:8];
            RD_IR_7_6: rf_waddr = ir_q[7:6];
            RD_LINK:   rf_waddr = RF_AW'(LINK_REG);
            default:   rf_waddr = ir_q[9:8];
        endcase
    end

    always_comb begin
        rf_wdata = alu_out_q;
        unique case (mem_to_reg_e'(ctrl_mem_to_reg))
            M2R_ALUOUT: rf_wdata = alu_out_q;
            M2R_MDR:    rf_wdata = mdr_q;
            M2R_PC:     rf_wdata = pc_q;
            M2R_IMM_HI: rf_wdata = WORD_W'({ir_q[7:0], 8'h00});
            default:    rf_wdata = alu_out_q;
        endcase
    end

    mc_regfile #(
        .WORD_W (WORD_W)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (commit & ctrl_reg_write),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (ir_q[11:10]),
        .raddr_b (ir_q[9:8]),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b)
    );

    // ---------------- architectural registers ----------------
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        mdr_d      = mdr_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_out_d  = alu_out_q;
        out_port_d = out_port_q;
        if (commit) begin
            if (ctrl_ir_write) ir_d = mem_rdata;
            if (mem_is_read)   mdr_d = mem_rdata;
            // A/B always reload from the IR that was current during this step
            a_d       = rf_rdata_a;
            b_d       = rf_rdata_b;
            alu_out_d = alu_res;
            if (ctrl_write_port) out_port_d = alu_out_q;
            if (pc_en)           pc_d = next_pc;
        end
    end

    // ---------------- run state / wait timeout ----------------
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            DP_RUN: begin
                if (mem_req && !mem_ack) begin
                    wait_d = wait_q + 1'b1;
                    if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
                        state_d = DP_BUSERR;
                        wait_d  = '0;
                    end
                end else begin
                    wait_d = '0;
                    if (commit && halt) state_d = DP_HALTED;
                end
            end
            // halted and bus error are terminal until reset
            default: wait_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q       <= WORD_W'(RESET_PC);
            ir_q       <= '0;
            mdr_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_out_q  <= '0;
            out_port_q <= '0;
            state_q    <= DP_RUN;
            wait_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mdr_q      <= mdr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            alu_out_q  <= alu_out_d;
            out_port_q <= out_port_d;
            state_q    <= state_d;
            wait_q     <= wait_d;
        end
    end

    assign inst        = ir_q;
    assign output_port = out_port_q;
    assign halted      = (state_q == DP_HALTED);
    assign bus_error   = (state_q == DP_BUSERR);

    // ---------------- performance counters ----------------
`ifdef MC_DP_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] commit_cnt_q, commit_cnt_d;

    always_comb begin
        cycle_cnt_d  = cycle_cnt_q + 32'd1;
        stall_cnt_d  = stall_cnt_q + {31'd0, stall & run};
        commit_cnt_d = commit_cnt_q + {31'd0, commit};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cycle_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            commit_cnt_q <= '0;
        end else begin
            cycle_cnt_q  <= cycle_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign cycle_cnt  = cycle_cnt_q;
    assign stall_cnt  = stall_cnt_q;
    assign commit_cnt = commit_cnt_q;
`else
    assign cycle_cnt  = '0;
    assign stall_cnt  = '0;
    assign commit_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed testbench for mc_datapath_hs (WORD_W=16, RESET_PC=0, WAIT_MAX=8).
module tb_mc_datapath_hs;

    logic        clk;
    logic        reset_n;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        ctrl_ir_write, ctrl_mem_read, ctrl_mem_write, ctrl_pc_write;
    logic        ctrl_pc_write_cond, ctrl_reg_write, ctrl_alu_src_a, ctrl_write_port, halt;
    logic [1:0]  ctrl_pc_source, ctrl_mem_to_reg, ctrl_reg_dst, ctrl_alu_src_b, ctrl_br_cond;
    logic [2:0]  ctrl_alu_op;
    logic [15:0] inst, output_port;
    logic        stall, bus_error, halted;
    logic [31:0] cycle_cnt, stall_cnt, commit_cnt;

    int unsigned n_vec;
    int unsigned n_err;

    mc_datapath_hs #(
        .WORD_W   (16),
        .RESET_PC (0),
        .WAIT_MAX (8),
        .LINK_REG (2)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .mem_ack            (mem_ack),
        .ctrl_ir_write      (ctrl_ir_write),
        .ctrl_mem_read      (ctrl_mem_read),
        .ctrl_mem_write     (ctrl_mem_write),
        .ctrl_pc_write      (ctrl_pc_write),
        .ctrl_pc_write_cond (ctrl_pc_write_cond),
        .ctrl_reg_write     (ctrl_reg_write),
        .ctrl_alu_src_a     (ctrl_alu_src_a),
        .ctrl_write_port    (ctrl_write_port),
        .halt               (halt),
        .ctrl_pc_source     (ctrl_pc_source),
        .ctrl_mem_to_reg    (ctrl_mem_to_reg),
        .ctrl_reg_dst       (ctrl_reg_dst),
        .ctrl_alu_src_b     (ctrl_alu_src_b),
        .ctrl_br_cond       (ctrl_br_cond),
        .ctrl_alu_op        (ctrl_alu_op),
        .inst               (inst),
        .output_port        (output_port),
        .stall              (stall),
        .bus_error          (bus_error),
        .halted             (halted),
        .cycle_cnt          (cycle_cnt),
        .stall_cnt          (stall_cnt),
        .commit_cnt         (commit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        ctrl_ir_write = 0; ctrl_mem_read = 0; ctrl_mem_write = 0; ctrl_pc_write = 0;
        ctrl_pc_write_cond = 0; ctrl_reg_write = 0; ctrl_alu_src_a = 0; ctrl_write_port = 0;
        halt = 0; ctrl_pc_source = 0; ctrl_mem_to_reg = 0; ctrl_reg_dst = 0;
        ctrl_alu_src_b = 0; ctrl_br_cond = 0; ctrl_alu_op = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // PC is visible on mem_addr while a fetch is requested; no edge is crossed
    task automatic peek_pc(input string tag, input logic [15:0] exp);
        ctrl_ir_write = 1; ctrl_mem_read = 0; ctrl_mem_write = 0; mem_ack = 0;
        #1 chk(tag, mem_addr, exp);
        ctrl_ir_write = 0;
        #1;
    endtask

    // ALUOut is visible on mem_addr while a data read is requested
    task automatic peek_aluout(input string tag, input logic [15:0] exp);
        ctrl_ir_write = 0; ctrl_mem_read = 1; ctrl_mem_write = 0; mem_ack = 0;
        #1 chk(tag, mem_addr, exp);
        chk({tag, "_we"}, mem_we, 0);
        ctrl_mem_read = 0;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clr();
        reset_n = 0; mem_ack = 1; mem_rdata = 16'h6A05; ctrl_ir_write = 1;
        #1 chk("rst_req", mem_req, 0);
        tick(); chk("rst_req1", mem_req, 0);
        tick(); chk("rst_req2", mem_req, 0);
        reset_n = 1; clr(); mem_ack = 0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_oport", output_port, 16'h0000);
        chk("rst_inst", inst, 16'h0000);
        chk("rst_halted", halted, 0);
        chk("rst_buserr", bus_error, 0);
        chk("rst_req3", mem_req, 0);
        peek_pc("rst_pc", 16'h0000);

        // fetch with 3 wait states
        clr(); ctrl_ir_write = 1; mem_rdata = 16'h6A05; mem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("fw_stall", stall, 1);
            chk("fw_addr", mem_addr, 16'h0000);
            tick();
            chk("fw_inst_hold", inst, 16'h0000);
            chk("fw_b_hold", mem_wdata, 16'h0000);
        end
        mem_ack = 1;
        #1 chk("fw_ack_stall", stall, 0);
        tick(); chk("fw_inst", inst, 16'h6A05);
        clr(); mem_ack = 0;

        // PC = 0 + sext(5)
        ctrl_alu_src_b = 2; ctrl_pc_write = 1;
        tick(); clr(); peek_pc("pc_imm", 16'h0005);
        // PC increment
        ctrl_alu_src_b = 1; ctrl_pc_write = 1;
        #1 chk("inc_stall", stall, 0);
        tick(); clr(); peek_pc("pc_inc", 16'h0006);
        // ALUOut = PC >>> 1 = 3
        ctrl_alu_op = 7;
        tick(); clr(); peek_aluout("sra", 16'h0003);
        // rf[LINK_REG=2] = ALUOut
        ctrl_reg_write = 1; ctrl_reg_dst = 2; ctrl_mem_to_reg = 0;
        tick(); clr();
        tick(); chk("b_eq3", mem_wdata, 16'h0003);

        // zero-wait fetch 6A3D (A,B index rf[2], imm 0x3D)
        ctrl_ir_write = 1; mem_ack = 1; mem_rdata = 16'h6A3D;
        #1 chk("zw_stall", stall, 0);
        tick(); chk("zw_inst", inst, 16'h6A3D);
        clr(); mem_ack = 0;
        // ALUOut = A(3) + 0x3D = 0x40
        ctrl_alu_src_a = 1; ctrl_alu_src_b = 2;
        tick(); clr(); peek_aluout("aluout40", 16'h0040);
        // A-B = 0, branch-if-zero to ALUOut
        ctrl_alu_src_a = 1; ctrl_alu_op = 1; ctrl_br_cond = 1; ctrl_pc_write_cond = 1; ctrl_pc_source = 1;
        tick(); clr(); peek_pc("br_taken", 16'h0040);

        // fetch 6B04: A <- rf[2], B <- rf[3]
        ctrl_ir_write = 1; mem_ack = 1; mem_rdata = 16'h6B04;
        tick(); chk("zw2_inst", inst, 16'h6B04);
        clr(); mem_ack = 0;
        ctrl_alu_src_a = 1; ctrl_alu_src_b = 1;
        tick(); clr(); peek_aluout("aluout4", 16'h0004);
        ctrl_reg_write = 1; ctrl_reg_dst = 0; ctrl_mem_to_reg = 0;
        tick(); clr(); chk("b_old0", mem_wdata, 16'h0000);
        ctrl_alu_src_b = 1;
        tick(); clr(); chk("b_eq4", mem_wdata, 16'h0004);
        // A-B = -1: branch-if-zero not taken, ALUOut (0x41) ignored
        ctrl_alu_src_a = 1; ctrl_alu_op = 1; ctrl_br_cond = 1; ctrl_pc_write_cond = 1; ctrl_pc_source = 1;
        tick(); clr(); peek_pc("br_not_taken", 16'h0040);
        // branch-if-negative taken to ALUOut = 0xFFFF
        ctrl_alu_src_a = 1; ctrl_alu_op = 1; ctrl_br_cond = 3; ctrl_pc_write_cond = 1; ctrl_pc_source = 1;
        tick(); clr(); peek_pc("br_ltz", 16'hFFFF);
        // WWD: output_port <- ALUOut (0xFFFF); ALUOut <- 0xFFFF + 4 = 3
        ctrl_write_port = 1;
        tick(); clr(); chk("oport", output_port, 16'hFFFF);

        // memory write with one wait state
        ctrl_mem_write = 1; mem_ack = 0;
        #1 chk("mw_req", mem_req, 1);
        chk("mw_we", mem_we, 1);
        chk("mw_addr", mem_addr, 16'h0003);
        chk("mw_wdata", mem_wdata, 16'h0004);
        chk("mw_stall", stall, 1);
        tick(); mem_ack = 1;
        #1 chk("mw_ack_stall", stall, 0);
        tick(); clr(); mem_ack = 0;
        // jump: {PC[15:12]=F, IR[11:0]=B04}
        ctrl_pc_write = 1; ctrl_pc_source = 2;
        tick(); clr(); peek_pc("jump", 16'hFB04);

        // halt
        halt = 1;
        #1 chk("halt_stall0", stall, 0);
        tick(); clr(); chk("halted", halted, 1);
        ctrl_ir_write = 1; mem_ack = 1; mem_rdata = 16'h1234;
        #1 chk("halt_req", mem_req, 0);
        chk("halt_stall", stall, 1);
        tick(); chk("halt_inst", inst, 16'h6B04);
        clr(); mem_ack = 0;

        reset_n = 0; tick(); reset_n = 1;
        #1 chk("rst2_halted", halted, 0);
        chk("rst2_inst", inst, 16'h0000);
        peek_pc("rst2_pc", 16'h0000);

        // reset mid-access clears the wait counter; then timeout after 8
        clr(); ctrl_ir_write = 1; mem_ack = 0;
        repeat (5) tick();
        reset_n = 0;
        #1 chk("rstmid_req", mem_req, 0);
        tick(); reset_n = 1;
        for (int i = 0; i < 7; i++) begin
            tick(); chk("to_pending", bus_error, 0);
        end
        tick();
        chk("to_buserr", bus_error, 1);
        chk("to_req", mem_req, 0);
        chk("to_stall", stall, 1);
        clr(); ctrl_pc_write = 1; ctrl_alu_src_b = 1; mem_ack = 1;
        tick(); clr();
        peek_pc("to_pc_frozen", 16'h0000);
        chk("to_sticky", bus_error, 1);

        // counters: 2 zero-wait commits, 3 waits + ack(halt), 4 halted cycles
        reset_n = 0; tick(); reset_n = 1; clr();
        ctrl_ir_write = 1; mem_ack = 1; mem_rdata = 16'h0000;
        tick(); tick();
        mem_ack = 0;
        tick(); tick(); tick();
        mem_ack = 1; halt = 1;
        tick();
        clr(); mem_ack = 0;
        repeat (4) tick();
        chk("pc_buserr_clr", bus_error, 0);
`ifdef MC_DP_PERF_CNT_EN
        chk("cycle_cnt", cycle_cnt, 32'd10);
        chk("stall_cnt", stall_cnt, 32'd3);
        chk("commit_cnt", commit_cnt, 32'd3);
`else
        chk("cycle_cnt_off", cycle_cnt, 32'd0);
        chk("stall_cnt_off", stall_cnt, 32'd0);
        chk("commit_cnt_off", commit_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
